// File: rtl/seqgen_pkg.sv
// Shared types and helpers for the serial pattern generator
// and its run-length golden model.
package seqgen_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_e;

   localparam int RUN_N_DEF = 4;

   function automatic int clamp_len(input int len_in, input int data_w);
      return (len_in > data_w) ? data_w : len_in;
   endfunction

endpackage

// File: rtl/serial_pattern_generator_run_length_model.sv
// Golden run-of-N model: flags every bit that completes a run of
// RUN_N or more equal bits; output is registered with the bit.
module run_length_model
   import seqgen_pkg::*;
#(
   parameter int RUN_N = RUN_N_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic bit_i,
   input  logic valid_i,
   input  logic clear_i,
   output logic z_o
);

   localparam int RW = $clog2(RUN_N + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(RUN_N);
   localparam logic [RW-1:0] RUN_ONE = RW'(1);

   logic          prev_q, prev_d;
   logic          hv_q, hv_d;
   logic [RW-1:0] run_q, run_d;
   logic          z_q, z_d;
   logic          same;

   always_comb begin
      prev_d = prev_q;
      hv_d   = hv_q;
      run_d  = run_q;
      z_d    = 1'b0;
      same   = 1'b0;
      if (clear_i) begin
         hv_d  = 1'b0;
         run_d = '0;
      end
      if (valid_i) begin
         // clear and valid together: the accepted bit starts a fresh run
         same = hv_d && (bit_i == prev_q);
         if (!same)
            run_d = RUN_ONE;
         else if (run_q < RUN_MAX)
            run_d = run_q + RUN_ONE;
         else
            run_d = run_q;
         prev_d = bit_i;
         hv_d   = 1'b1;
         z_d    = (run_d >= RUN_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 1'b0;
         hv_q   <= 1'b0;
         run_q  <= '0;
         z_q    <= 1'b0;
      end else begin
         prev_q <= prev_d;
         hv_q   <= hv_d;
         run_q  <= run_d;
         z_q    <= z_d;
      end
   end

   assign z_o = z_q;

endmodule

// File: rtl/serial_pattern_generator.sv
// MSB-first serial transmitter with repeat passes, programmable
// idle level and an aligned run-of-four expectation output.
module serial_pattern_generator
   import seqgen_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 5,
   parameter int REP_W  = 4,
   parameter int RUN_N  = RUN_N_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic [LEN_W-1:0]  len_in,
   input  logic [REP_W-1:0]  rep_in,
   input  logic              idle_level,
   output logic              x,
   output logic              busy,
   output logic              done,
   output logic              expect_z
);

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
   localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [REP_W-1:0]  rep_q, rep_d;
   logic              x_q, x_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              emit_v, emit_clr;
   logic [LEN_W-1:0]  acc_len;

   function automatic logic bit_at(input logic [DATA_W-1:0] d,
                                   input logic [LEN_W-1:0] i);
      logic [DATA_W-1:0] s;
      s = d >> i;
      return s[0];
   endfunction

   always_comb begin
      acc_len  = LEN_W'(clamp_len(int'(len_in), DATA_W));
      state_d  = state_q;
      data_d   = data_q;
      len_d    = len_q;
      idx_d    = idx_q;
      rep_d    = rep_q;
      x_d      = idle_level;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      emit_v   = 1'b0;
      emit_clr = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (acc_len != '0) begin
                  data_d   = data_in;
                  len_d    = acc_len;
                  rep_d    = rep_in;
                  idx_d    = acc_len - LEN_ONE;
                  x_d      = bit_at(data_in, acc_len - LEN_ONE);
                  busy_d   = 1'b1;
                  emit_v   = 1'b1;
                  emit_clr = 1'b1;
                  state_d  = S_SHIFT;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            busy_d = 1'b1;
            emit_v = 1'b1;
            if (idx_q != '0) begin
               idx_d = idx_q - LEN_ONE;
               x_d   = bit_at(data_q, idx_q - LEN_ONE);
            end else if (rep_q != '0) begin
               // wrap straight into the next pass, no gap cycle
               rep_d = rep_q - REP_ONE;
               idx_d = len_q - LEN_ONE;
               x_d   = bit_at(data_q, len_q - LEN_ONE);
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               emit_v  = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         rep_q   <= '0;
         x_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         rep_q   <= rep_d;
         x_q     <= x_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   run_length_model #(
      .RUN_N(RUN_N)
   ) u_rlm (
      .clk    (clk),
      .rst    (rst),
      .bit_i  (x_d),
      .valid_i(emit_v),
      .clear_i(emit_clr),
      .z_o    (expect_z)
   );

   assign x    = x_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
